uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path (the uart_txmt_top write port: wr_uart, w_data, tx_fifo_full) among NREQ byte-stream requesters.
- Grants per packet, round-robin, so bytes from different requesters never interleave on the line.
- Sits between the requester logic and uart_txmt_top.
- Includes an idle-timeout watchdog so a stalled requester cannot hold the transmitter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data byte width; matches uart_txmt_top WIDTH.
- TIMEOUT, 1024, cycles a granted requester may leave req_valid low mid-packet before its grant is revoked.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*WIDTH  per-requester byte; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  NREQ  marks final byte of the requester's packet
- req_ready  out  NREQ  per-requester accept
- tx_fifo_full  in  1  from uart_txmt_top
- wr_uart  out  1  write strobe to uart_txmt_top
- w_data  out  WIDTH  byte to uart_txmt_top
- grant_id  out  $clog2(NREQ)  currently granted requester (valid while busy=1)
- busy  out  1  a packet grant is active
- abort  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (reset=0, async) forces state=IDLE, rr_ptr=0, grant_id=0, busy=0, abort=0, idle counter=0.
- While in reset, combinational outputs req_ready=0, wr_uart=0, w_data=0.
- FSM states: IDLE, XFER (plus TAG when UART_CHAN_TAG_EN is defined).
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ.
  - First set bit i is latched into grant_id; busy=1; go to XFER on the next clock.
  - No data moves in IDLE, so a packet's first byte is accepted at the earliest one cycle after req_valid rises.
- XFER handshake:
  - req_ready[grant_id] = ~tx_fifo_full; all other req_ready bits = 0.
  - A beat occurs when req_valid[g] & req_ready[g].
  - wr_uart = beat (combinational, zero latency); w_data = req_data slice g when beat, else 0.
  - tx_fifo_full=1 stalls: req_ready=0, wr_uart=0, and the idle counter does not advance.
- End of packet:
  - A beat with req_last[g]=1 ends the packet: rr_ptr <= (g+1) mod NREQ; busy<=0; state<=IDLE.
  - The next grant decision happens in the following IDLE cycle.
  - A single-byte packet (first beat has last=1) is legal.
- Watchdog:
  - The counter increments each XFER cycle with req_valid[g]=0 and tx_fifo_full=0.
  - It clears on any beat.
  - When it reaches TIMEOUT-1: abort=1 for one cycle, rr_ptr<=(g+1) mod NREQ, state<=IDLE, busy<=0.
  - The partial packet is not padded.
- Fairness: a requester that keeps req_valid high is re-granted only after every other valid requester has had one packet.
- Requesters not granted see req_ready=0 and must hold their data; the arbiter never drops a byte it has not acknowledged.
- Reset asserted mid-packet: immediate return to IDLE; a partial packet already written to the FIFO is not recalled.
- grant_id holds its last value while busy=0.

Optional Feature:
- Macro: UART_CHAN_TAG_EN.
- When defined:
  - IDLE->TAG->XFER.
  - In TAG, if tx_fifo_full=0, wr_uart=1 with w_data = {1'b1, {(WIDTH-4){1'b0}}, grant_id zero-extended to 3 bits}; e.g. requester 2 gives 8'h82. Then go to XFER.
  - If tx_fifo_full=1, stay in TAG.
  - req_ready=0 throughout TAG; the watchdog is inactive in TAG.
- When undefined: the TAG state and its logic are absent; behaviour is exactly as above.

Test Plan:
- Reset, single requester 0 sends 3-byte packet 8'h11,8'h22,8'h33 (last on 33), tx_fifo_full=0 -> wr_uart high 3 cycles starting one cycle after req_valid, w_data 11,22,33; busy drops after the 33 beat; rr_ptr=1.
- Requesters 1 and 3 both valid from IDLE with rr_ptr=0 -> grant_id=1 first, whole packet sent, then grant_id=3; no interleaved bytes.
- Requester 0 continuously valid with 1-byte packets, requester 2 valid -> grants alternate 0,2,0,2.
- tx_fifo_full held 5 cycles mid-packet -> req_ready=0 and wr_uart=0 for those 5 cycles; no byte lost or duplicated; watchdog not advanced.
- Granted requester drops req_valid for TIMEOUT cycles after 1 byte -> abort pulses once, busy=0, next valid requester granted.
- UART_CHAN_TAG_EN defined, requester 2 sends 8'hA5 (last) -> wr_uart writes 8'h82 then 8'hA5 on consecutive cycles; reset asserted during TAG -> busy=0, wr_uart=0 immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-packet round-robin arbiter sharing one UART transmit write port among NREQ requesters.
// Ports: clk, reset (async active-low); req_valid/req_data/req_last/req_ready per-requester byte streams;
// tx_fifo_full in, wr_uart/w_data out toward uart_txmt_top; grant_id/busy report the active grant;
// abort pulses when the idle watchdog revokes a grant.
// Optional: define UART_CHAN_TAG_EN to prefix each packet with a channel tag byte.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      tx_fifo_full,
  output logic                      wr_uart,
  output logic [WIDTH-1:0]          w_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      abort
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef UART_CHAN_TAG_EN
  typedef enum logic [1:0] {IDLE, XFER, TAG} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, rr_n, gid_n, pick, hi, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic busy_n, abort_n, found, hi_found, beat;
  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall (wrap).
  always_comb begin
    pick = '0;
    hi = '0;
    found = 1'b0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i]) begin
        pick = GW'(i);
        found = 1'b1;
        if (GW'(i) >= rr_ptr) begin
          hi = GW'(i);
          hi_found = 1'b1;
        end
      end
    if (hi_found) pick = hi;
  end
  assign nxt = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      abort    <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      grant_id <= gid_n;
      busy     <= busy_n;
      abort    <= abort_n;
      cnt      <= cnt_n;
    end
  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    gid_n     = grant_id;
    busy_n    = busy;
    abort_n   = 1'b0;
    cnt_n     = cnt;
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (found) begin
          gid_n  = pick;
          busy_n = 1'b1;
`ifdef UART_CHAN_TAG_EN
          state_n = TAG;
`else
          state_n = XFER;
`endif
        end
      end
`ifdef UART_CHAN_TAG_EN
      TAG:
        if (!tx_fifo_full) begin
          wr_uart = 1'b1;
          w_data  = {1'b1, {(WIDTH-4){1'b0}}, 3'(grant_id)};
          state_n = XFER;
        end
`endif
      XFER: begin
        req_ready[grant_id] = ~tx_fifo_full;
        beat = req_valid[grant_id] & ~tx_fifo_full;
        if (beat) begin
          wr_uart = 1'b1;
          w_data  = req_data[grant_id*WIDTH +: WIDTH];
          cnt_n   = '0;
          if (req_last[grant_id]) begin
            rr_n    = nxt;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (!tx_fifo_full) begin
          // Watchdog: only requester-idle cycles count; a full FIFO is not the requester's fault.
          if (cnt == CW'(TIMEOUT - 1)) begin
            abort_n = 1'b1;
            rr_n    = nxt;
            busy_n  = 1'b0;
            state_n = IDLE;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven plus directed-sequence self-checking bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, reset = 1'b0, tx_fifo_full = 1'b0, wr_uart, busy, abort;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic [7:0] w_data;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] v, l;
    logic [31:0] d;
    logic f, wr;
    logic [7:0] wd;
    logic [3:0] rdy;
    logic bsy;
    logic [1:0] gid;
  } vec_t;
  vec_t tbl[$];
  uart_tx_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_fifo_full(tx_fifo_full), .wr_uart(wr_uart), .w_data(w_data),
    .grant_id(grant_id), .busy(busy), .abort(abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_all(input string n, input logic wr, input logic [7:0] wd, input logic [3:0] rdy,
                         input logic bsy, input logic [1:0] gid, input logic ab);
    chk({n, " wr_uart"}, 32'(wr_uart), 32'(wr));
    chk({n, " w_data"}, 32'(w_data), 32'(wd));
    chk({n, " req_ready"}, 32'(req_ready), 32'(rdy));
    chk({n, " busy"}, 32'(busy), 32'(bsy));
    chk({n, " grant_id"}, 32'(grant_id), 32'(gid));
    chk({n, " abort"}, 32'(abort), 32'(ab));
  endtask
  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f,
                     input logic wr, input logic [7:0] wd, input logic [3:0] rdy, input logic bsy,
                     input logic [1:0] gid);
    tbl.push_back('{v, l, d, f, wr, wd, rdy, bsy, gid});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
    req_valid = v;
    req_last = l;
    req_data = d;
    tx_fifo_full = f;
  endtask
  initial begin
    // requester 0: 11,22,33
    add(4'h1, 4'h0, 32'h00000011, 0, 0, 8'h00, 4'h0, 0, 0);
    add(4'h1, 4'h0, 32'h00000011, 0, 1, 8'h11, 4'h1, 1, 0);
    add(4'h1, 4'h0, 32'h00000022, 0, 1, 8'h22, 4'h1, 1, 0);
    add(4'h1, 4'h1, 32'h00000033, 0, 1, 8'h33, 4'h1, 1, 0);
    add(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 0, 0);
    // requesters 1 and 3 contend, rr_ptr=1
    add(4'hA, 4'h0, 32'hD100A100, 0, 0, 8'h00, 4'h0, 0, 0);
    add(4'hA, 4'h0, 32'hD100A100, 0, 1, 8'hA1, 4'h2, 1, 1);
    add(4'hA, 4'h2, 32'hD100A200, 0, 1, 8'hA2, 4'h2, 1, 1);
    add(4'h8, 4'h8, 32'hD1000000, 0, 0, 8'h00, 4'h0, 0, 1);
    add(4'h8, 4'h8, 32'hD1000000, 0, 1, 8'hD1, 4'h8, 1, 3);
    // requesters 0 and 2, single-byte packets, alternate
    add(4'h5, 4'h5, 32'h00C000B0, 0, 0, 8'h00, 4'h0, 0, 3);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 1, 8'hB0, 4'h1, 1, 0);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 0, 8'h00, 4'h0, 0, 0);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 1, 8'hC0, 4'h4, 1, 2);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 0, 8'h00, 4'h0, 0, 2);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 1, 8'hB0, 4'h1, 1, 0);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 0, 8'h00, 4'h0, 0, 0);
    add(4'h5, 4'h5, 32'h00C000B0, 0, 1, 8'hC0, 4'h4, 1, 2);
    add(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 0, 2);
    // rr_ptr=3 wraps to requester 0; 5-cycle FIFO-full stall mid-packet
    add(4'h1, 4'h0, 32'h000000E1, 0, 0, 8'h00, 4'h0, 0, 2);
    add(4'h1, 4'h0, 32'h000000E1, 0, 1, 8'hE1, 4'h1, 1, 0);
    for (int i = 0; i < 5; i++) add(4'h1, 4'h0, 32'h000000E2, 1, 0, 8'h00, 4'h0, 1, 0);
    add(4'h1, 4'h0, 32'h000000E2, 0, 1, 8'hE2, 4'h1, 1, 0);
    add(4'h1, 4'h1, 32'h000000E3, 0, 1, 8'hE3, 4'h1, 1, 0);
    add(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 0, 0);
    // reset state: combinational outputs stay low even with requests pending
    drive(4'hF, 4'hF, 32'h44332211, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 8'h00, 4'h0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].v, tbl[r].l, tbl[r].d, tbl[r].f);
      @(negedge clk);
      chk_all($sformatf("row%0d", r), tbl[r].wr, tbl[r].wd, tbl[r].rdy, tbl[r].bsy, tbl[r].gid, 0);
      cyc();
    end
    // watchdog: one byte, long full stall (no count), then TO idle cycles -> abort
    drive(4'h2, 4'h0, 32'h0000F100, 0);
    @(negedge clk);
    chk_all("wd_idle", 0, 8'h00, 4'h0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk_all("wd_beat", 1, 8'hF1, 4'h2, 1, 1, 0);
    cyc();
    drive(4'h4, 4'h4, 32'h00C70000, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_all($sformatf("wd_full%0d", i), 0, 8'h00, 4'h0, 1, 1, 0);
      cyc();
    end
    tx_fifo_full = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk_all($sformatf("wd_cnt%0d", k), 0, 8'h00, 4'h2, 1, 1, 0);
      cyc();
    end
    @(negedge clk);
    chk_all("wd_abort", 0, 8'h00, 4'h0, 0, 1, 1);
    cyc();
    @(negedge clk);
    chk_all("wd_next", 1, 8'hC7, 4'h4, 1, 2, 0);
    cyc();
    // reset mid-packet acts immediately
    drive(4'h1, 4'h0, 32'h00000099, 0);
    @(negedge clk);
    chk_all("mr_idle", 0, 8'h00, 4'h0, 0, 2, 0);
    cyc();
    @(negedge clk);
    chk_all("mr_beat", 1, 8'h99, 4'h1, 1, 0, 0);
    #2 reset = 1'b0;
    #1 chk_all("mr_reset", 0, 8'h00, 4'h0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    // rr_ptr back to 0: requester 1 beats requester 3
    drive(4'hA, 4'h0, 32'h77005500, 0);
    @(negedge clk);
    chk_all("mr_rel", 0, 8'h00, 4'h0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk_all("mr_rr", 1, 8'h55, 4'h2, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
